f2_op_queue: RTL and testbench
==============================

Name: f2_op_queue

Overview:
- Operand issue queue sitting directly upstream of the F2 function unit (abs / min-max / shift-right-by-3 / zero).
- Buffers up to DEPTH operation bundles {f, in0, in1, in2} from the decode/dispatch stage behind a valid/ready handshake.
- Presents the oldest bundle to F2 with its own valid/ready handshake.
- Decouples dispatch stalls from the downstream result register.

Parameters:
- WIDTH, 32, operand width; matches F2 WIDTH.
- DEPTH, 4, number of queue entries; power of two, ≥2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- flush  input  1  synchronous queue clear.
- in_valid  input  1  upstream bundle valid.
- in_ready  output  1  queue can accept a bundle this cycle.
- in_f  input  2  function select for F2.
- in_in0  input  WIDTH  operand 0.
- in_in1  input  WIDTH  operand 1.
- in_in2  input  WIDTH  operand 2 (carried unmodified).
- out_valid  output  1  head bundle valid.
- out_ready  input  1  F2 stage consumes head this cycle.
- out_f  output  2  head function select.
- out_in0  output  WIDTH  head operand 0.
- out_in1  output  WIDTH  head operand 1.
- out_in2  output  WIDTH  head operand 2.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset is synchronous, active-low: on a rising edge with rst_n=0, wr_ptr, rd_ptr and count go to 0. Entry storage is not reset.
- After the reset edge: out_valid=0, count=0, out_f/out_in*=0. in_ready=0 while rst_n=0.
- push = in_valid & in_ready; pop = out_valid & out_ready. Both are evaluated in the same cycle.
- in_ready = rst_n & ~flush & (count != DEPTH). It does not depend on out_ready: no push-when-full-with-pop.
- out_valid = (count != 0). Outputs are driven from the head entry (registered storage).
- When count==0, out_f and out_in0..2 are driven to all zeros.
- Latency: a bundle pushed at edge N is visible on out_* in the cycle after edge N. There is no same-cycle bypass.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally. count tracks occupancy 0..DEPTH.
- Update rules per edge (when rst_n=1, flush=0):
  - push only: write at wr_ptr, wr_ptr+1, count+1.
  - pop only: rd_ptr+1, count-1.
  - push and pop: write and advance both pointers; count unchanged. Legal at any count 1..DEPTH-1.
- Full (count==DEPTH): in_ready=0. A pop that cycle frees a slot; in_ready returns to 1 in the next cycle.
- Empty (count==0): out_valid=0, so out_ready is ignored and pop cannot occur.
- Flush (rst_n=1, flush=1): at the edge, pointers and count go to 0; any push or pop that cycle is discarded. in_ready=0 during the flush cycle.
- Reset or flush mid-stream discards all queued bundles. No partial bundle is ever emitted.
- Bundles leave in exact arrival order. All f values 0..3 pass through unmodified; f=3 (zero op) is a legal bundle.
- out_* hold stable while out_valid=1 and out_ready=0.

Decomposition:
- Shared package f2_pkg holds:
  - F2 function codes: F2_ABS=2'd0, F2_MINMAX=2'd1, F2_SHR3=2'd2, F2_ZERO=2'd3.
  - F2_WIDTH default = 32.
  - Bundle width constant: 2 + 3*WIDTH.
  - Packed bundle typedef f2_bundle_t {f, in0, in1, in2}.
- Optional sub-module f2_bundle_mem: DEPTH x bundle storage, 1 write / 1 async read. All control (pointers, count, handshake) stays in f2_op_queue.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 → in_ready=0, and after release out_valid=0, count=0, out_in0=0.
- Ordering: push 4 bundles (f=0..3, in0=0x10..0x13) with out_ready=0 → count=4, in_ready=0. Then set out_ready=1 → outputs pop f=0,1,2,3 and in0=0x10..0x13 in order over 4 cycles.
- Full boundary: with count=4, in_valid=1, out_ready=1 → one pop; no push that cycle; in_ready=1 next cycle; count goes 3 then back to 4 on the following push.
- Simultaneous push/pop: at count=2, continuous push and pop for 10 cycles with in0 incrementing from 0x100 → count stays 2; out_in0 sequence trails input by exactly 2 bundles; pointers wrap without error.
- Flush: with count=3, assert flush for 1 cycle together with in_valid=1 → next cycle count=0, out_valid=0, and the bundle offered during flush does not appear.
- Stall stability: head bundle {f=1, in0=0xFFFFFFF8, in1=5, in2=0xA5A5A5A5} with out_ready=0 for 5 cycles → out_* constant and out_valid=1 throughout.

Source files
------------

// File: rtl/f2_pkg.sv
// Shared F2 definitions: function codes, default operand width and the
// packed operation bundle carried from dispatch into the F2 unit.
package f2_pkg;

  typedef enum logic [1:0] {
    F2_ABS    = 2'd0,
    F2_MINMAX = 2'd1,
    F2_SHR3   = 2'd2,
    F2_ZERO   = 2'd3
  } f2_func_e;

  localparam int F2_WIDTH = 32;

  // {f, in0, in1, in2} flattened width for a given operand width.
  function automatic int f2_bundle_w(input int w);
    return 2 + 3 * w;
  endfunction

  localparam int F2_BUNDLE_W = f2_bundle_w(F2_WIDTH);

  typedef struct packed {
    logic [1:0]          f;
    logic [F2_WIDTH-1:0] in0;
    logic [F2_WIDTH-1:0] in1;
    logic [F2_WIDTH-1:0] in2;
  } f2_bundle_t;

endpackage

// File: rtl/f2_bundle_mem.sv
// Bundle storage for the F2 issue queue: one write port, one async read port.
// Contents are deliberately not reset; validity is tracked by the queue.
module f2_bundle_mem #(
  parameter int BW    = 98,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [BW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [BW-1:0] rdata
);

  logic [BW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/f2_op_queue.sv
// Operand issue queue in front of the F2 unit: buffers up to DEPTH bundles
// and presents the oldest one with its own valid/ready handshake.
module f2_op_queue
  import f2_pkg::*;
#(
  parameter int WIDTH = F2_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_f,
  input  logic [WIDTH-1:0]         in_in0,
  input  logic [WIDTH-1:0]         in_in1,
  input  logic [WIDTH-1:0]         in_in2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_f,
  output logic [WIDTH-1:0]         out_in0,
  output logic [WIDTH-1:0]         out_in1,
  output logic [WIDTH-1:0]         out_in2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = f2_bundle_w(WIDTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [BW-1:0] wr_bundle, rd_bundle;

  // No push-when-full-with-pop: a freed slot only opens on the next cycle.
  assign in_ready  = rst_n & ~flush & (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_bundle = {in_f, in_in0, in_in1, in_in2};

  f2_bundle_mem #(
    .BW    (BW),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_bundle),
    .raddr (rd_ptr_q),
    .rdata (rd_bundle)
  );

  // Stale storage is masked so an empty queue always shows zeros.
  assign {out_f, out_in0, out_in1, out_in2} = out_valid ? rd_bundle : '0;
  assign count = count_q;

endmodule

// File: tb/tb_f2_op_queue.sv
// Scoreboard bench for f2_op_queue: a queue-based reference model tracks the
// expected contents; a negedge monitor checks handshake, occupancy and head.
module tb_f2_op_queue;
  import f2_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, out_ready;
  logic             in_ready, out_valid;
  logic [1:0]       in_f, out_f;
  logic [WIDTH-1:0] in_in0, in_in1, in_in2, out_in0, out_in1, out_in2;
  logic [CW-1:0]    count;

  int n_checks = 0;
  int n_errors = 0;
  f2_bundle_t sb[$];

  f2_op_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_f(in_f),
    .in_in0(in_in0), .in_in1(in_in1), .in_in2(in_in2),
    .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f),
    .out_in0(out_in0), .out_in1(out_in1), .out_in2(out_in2),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the DUT against the model, then advance the model with
  // the handshakes that the coming rising edge will perform.
  always @(negedge clk) begin
    f2_bundle_t head, exp_b;
    logic       m_in_ready, m_push, m_pop;
    if (!rst_n) begin
      chk("in_ready_in_reset", {127'b0, in_ready}, 128'd0);
      sb.delete();
    end else begin
      m_in_ready = !flush && (sb.size() < DEPTH);
      chk("count", {{(128-CW){1'b0}}, count}, 128'(sb.size()));
      chk("out_valid", {127'b0, out_valid}, {127'b0, sb.size() != 0});
      chk("in_ready", {127'b0, in_ready}, {127'b0, m_in_ready});
      head = '{f: out_f, in0: out_in0, in1: out_in1, in2: out_in2};
      exp_b = (sb.size() != 0) ? sb[0] : '0;
      chk("head_bundle", 128'(head), 128'(exp_b));
      if (flush) sb.delete();
      else begin
        m_push = in_valid && m_in_ready;
        m_pop  = out_ready && (sb.size() != 0);
        if (m_pop) void'(sb.pop_front());
        if (m_push) sb.push_back('{f: in_f, in0: in_in0, in1: in_in1, in2: in_in2});
      end
    end
  end

  task automatic drive(input logic v, input logic [1:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c,
                       input logic ordy, input logic fl);
    in_valid = v; in_f = f; in_in0 = a; in_in1 = b; in_in2 = c;
    out_ready = ordy; flush = fl;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 32'd0, 32'd0, 32'd0, ordy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_f = 2'd1; in_in0 = 32'h55; in_in1 = 32'h66; in_in2 = 32'h77;
    // Reset held two cycles with a bundle offered.
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1, 1'b0);
    chk("reset_count", {{(128-CW){1'b0}}, count}, 128'd0);
    chk("reset_out_in0", 128'(out_in0), 128'd0);

    // Ordering: fill with f=0..3, then drain.
    for (int i = 0; i < 4; i++)
      drive(1'b1, 2'(i), 32'h10 + i, 32'(i), 32'hA0 + i, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("full_count", {{(128-CW){1'b0}}, count}, 128'd4);
    chk("full_in_ready", {127'b0, in_ready}, 128'd0);
    idle(4, 1'b1);

    // Full boundary: pop while offering, then the push lands next cycle.
    for (int i = 0; i < 4; i++)
      drive(1'b1, 2'(i), 32'h20 + i, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 32'h24, 32'd1, 32'd2, 1'b1, 1'b0);
    chk("after_full_pop_count", {{(128-CW){1'b0}}, count}, 128'd3);
    chk("after_full_pop_ready", {127'b0, in_ready}, 128'd1);
    drive(1'b1, 2'd2, 32'h24, 32'd1, 32'd2, 1'b0, 1'b0);
    chk("refill_count", {{(128-CW){1'b0}}, count}, 128'd4);
    idle(5, 1'b1);

    // Simultaneous push/pop at count=2 across pointer wrap.
    drive(1'b1, 2'd0, 32'h0FE, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 32'h0FF, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      drive(1'b1, 2'(i), 32'h100 + i, 32'(i), 32'(~i), 1'b1, 1'b0);
    chk("stream_count", {{(128-CW){1'b0}}, count}, 128'd2);
    chk("stream_head", 128'(out_in0), 128'h108);
    idle(3, 1'b1);

    // Flush with a bundle offered in the same cycle.
    for (int i = 0; i < 3; i++)
      drive(1'b1, 2'd3, 32'h30 + i, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 32'hDEAD, 32'd0, 32'd0, 1'b1, 1'b1);
    chk("flush_count", {{(128-CW){1'b0}}, count}, 128'd0);
    chk("flush_out_valid", {127'b0, out_valid}, 128'd0);
    idle(2, 1'b1);

    // Stall stability: head held for 5 cycles.
    drive(1'b1, 2'd1, 32'hFFFF_FFF8, 32'd5, 32'hA5A5_A5A5, 1'b0, 1'b0);
    idle(5, 1'b0);
    chk("stall_in0", 128'(out_in0), 128'hFFFF_FFF8);
    idle(2, 1'b1);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 2) != 0, 2'($urandom), $urandom, $urandom, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    end
    rst_n = 1'b1;
    idle(6, 1'b1);
    chk("drained_count", {{(128-CW){1'b0}}, count}, 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
